calc_alu_seq: RTL and testbench

Multi-cycle arithmetic sequencer for the calculator datapath. It accepts two 6-digit BCD operands and a key-encoded opcode from the keypad input controller. It converts the operands to binary, executes add, subtract, multiply or divide on one shared 20-bit iterative engine, and converts the result back to BCD. The BCD result, sign and error flags are returned to the input controller's result port, using a start/done handshake.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/bin2bcd_dd.sv | 47 ++++
 rtl/calc_alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_calc_alu_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants, opcodes and FSM state type for the calculator arithmetic sequencer.
package calc_pkg;

    localparam int DIGITS = 6;
    localparam int BIN_W  = 20;

    localparam logic [3:0] OP_ADD = 4'ha;
    localparam logic [3:0] OP_SUB = 4'hb;
    localparam logic [3:0] OP_MUL = 4'hc;
    localparam logic [3:0] OP_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ = 4'he;

    localparam logic [23:0]      SAT_BCD = 24'h999999;
    localparam logic [BIN_W-1:0] MAX_BIN = 20'd999999;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        CONV,
        DONE
    } state_t;

    // Double-dabble adjust: add 3 to every BCD digit that is 5 or more.
    function automatic logic [23:0] dabble(input logic [23:0] bcd);
        logic [23:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return adj;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential 20-bit binary to 6-digit BCD converter (double-dabble, one bit per cycle).
// The load edge consumes the first bit; busy for 19 more edges, then ready until the next load.
module bin2bcd_dd
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [19:0] bin_in,
    output logic        busy,
    output logic        ready,
    output logic [23:0] bcd_out
);

    logic [19:0] sh;
    logic [4:0]  cnt;
    logic [23:0] adj;

    assign adj = dabble(bcd_out);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            bcd_out <= '0;
        end else if (load) begin
            // first adjust of an all-zero BCD register is a no-op, so shift immediately
            sh      <= {bin_in[18:0], 1'b0};
            bcd_out <= {23'd0, bin_in[19]};
            cnt     <= 5'd19;
            busy    <= 1'b1;
            ready   <= 1'b0;
        end else if (busy) begin
            bcd_out <= {adj[22:0], sh[19]};
            // adj[23] only matters above 999999 (result forced); park it in sh's spent low end
            sh      <= {sh[18:0], adj[23]};
            cnt     <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                busy  <= 1'b0;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_alu_seq.sv
// BCD add/sub/mul/div sequencer: BCD->binary load, shared iterative engine, double-dabble back.
// Fixed latency 28 (add/sub) or 47 (mul/div) edges; CALC_DIV_EN compiles in the divider.
module calc_alu_seq
    import calc_pkg::*;
(
    input  logic        CLK_1K,
    input  logic        RSTN,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [23:0] num_a,
    input  logic [23:0] num_b,
    output logic        busy,
    output logic        done,
    output logic [23:0] num_result,
    output logic        neg,
    output logic        ovf,
    output logic        err
);

    state_t state, state_next;

    logic [3:0]       op_q;
    logic [23:0]      dig_a, dig_b;
    logic [BIN_W-1:0] bin_a, bin_b, res_bin;
    logic [4:0]       cnt;
    logic [39:0]      acc, cur, next_acc;
    logic [20:0]      sum_ab, mul_sum;
    logic             err_q, neg_q, ovf_q;
    logic             op_ok, is_long;
    logic             conv_loaded, conv_load, conv_fin;
    logic             conv_busy, conv_ready;
    logic [23:0]      conv_bcd;
`ifdef CALC_DIV_EN
    logic [40:0]      div_sh;
    logic [19:0]      div_rem;
    logic             div_ge;
`endif

    assign busy    = (state != IDLE);
    assign is_long = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign sum_ab  = {1'b0, bin_a} + {1'b0, bin_b};

`ifdef CALC_DIV_EN
    assign op_ok = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_MUL) || (opcode == OP_DIV);
`else
    assign op_ok = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_MUL);
`endif

    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        conv_load  = 1'b0;
        conv_fin   = 1'b0;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: if (cnt == 5'd5) state_next = EXEC;
            EXEC: if (!is_long || cnt == 5'd19) state_next = CONV;
            CONV: begin
                if (!conv_loaded) begin
                    conv_load = 1'b1;
                end else if (conv_ready && !conv_busy) begin
                    conv_fin   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One engine step; acc holds {high, low} halves for both shift-add and restoring division.
    always_comb begin
        cur      = (cnt == 5'd0) ? {20'd0, bin_a} : acc;
        mul_sum  = {1'b0, cur[39:20]} + (cur[0] ? {1'b0, bin_b} : 21'd0);
        next_acc = cur;
`ifdef CALC_DIV_EN
        div_sh  = {cur, 1'b0};
        div_ge  = div_sh[40:20] >= {1'b0, bin_b};
        div_rem = div_sh[39:20] - bin_b;
`endif
        if (op_q == OP_MUL)
            next_acc = {mul_sum, cur[19:1]};
`ifdef CALC_DIV_EN
        else if (op_q == OP_DIV && bin_b != '0)
            next_acc = div_ge ? {div_rem, div_sh[19:1], 1'b1} : div_sh[39:0];
`endif
    end

    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            op_q        <= '0;
            dig_a       <= '0;
            dig_b       <= '0;
            bin_a       <= '0;
            bin_b       <= '0;
            res_bin     <= '0;
            cnt         <= '0;
            acc         <= '0;
            err_q       <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            conv_loaded <= 1'b0;
            done        <= 1'b0;
            num_result  <= '0;
            neg         <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= conv_fin;
            case (state)
                IDLE: if (start) begin
                    op_q        <= opcode;
                    dig_a       <= num_a;
                    dig_b       <= num_b;
                    bin_a       <= '0;
                    bin_b       <= '0;
                    cnt         <= '0;
                    err_q       <= !op_ok;
                    neg_q       <= 1'b0;
                    ovf_q       <= 1'b0;
                    conv_loaded <= 1'b0;
                end
                LOAD: begin
                    bin_a <= {bin_a[16:0], 3'b000} + {bin_a[18:0], 1'b0} + {16'd0, dig_a[23:20]};
                    bin_b <= {bin_b[16:0], 3'b000} + {bin_b[18:0], 1'b0} + {16'd0, dig_b[23:20]};
                    dig_a <= {dig_a[19:0], 4'h0};
                    dig_b <= {dig_b[19:0], 4'h0};
                    if (dig_a[23:20] > 4'd9 || dig_b[23:20] > 4'd9) err_q <= 1'b1;
                    cnt <= (cnt == 5'd5) ? 5'd0 : cnt + 5'd1;
                end
                EXEC: begin
                    acc <= next_acc;
                    cnt <= cnt + 5'd1;
                    case (op_q)
                        OP_ADD: begin
                            res_bin <= sum_ab[19:0];
                            ovf_q   <= sum_ab > {1'b0, MAX_BIN};
                        end
                        OP_SUB: begin
                            if (bin_a < bin_b) begin
                                neg_q   <= 1'b1;
                                res_bin <= bin_b - bin_a;
                            end else begin
                                res_bin <= bin_a - bin_b;
                            end
                        end
                        OP_MUL: if (cnt == 5'd19) begin
                            res_bin <= next_acc[19:0];
                            ovf_q   <= next_acc > {20'd0, MAX_BIN};
                        end
`ifdef CALC_DIV_EN
                        OP_DIV: begin
                            if (bin_b == '0) err_q <= 1'b1;
                            if (cnt == 5'd19) res_bin <= next_acc[19:0];
                        end
`endif
                        default: ;
                    endcase
                end
                CONV: if (conv_load) conv_loaded <= 1'b1;
                default: ;
            endcase
            if (conv_fin) begin
                num_result <= err_q ? 24'd0 : (ovf_q ? SAT_BCD : conv_bcd);
                neg        <= !err_q && neg_q;
                ovf        <= !err_q && ovf_q;
                err        <= err_q;
            end
        end
    end

    bin2bcd_dd u_bin2bcd (
        .clk     (CLK_1K),
        .rstn    (RSTN),
        .load    (conv_load),
        .bin_in  (res_bin),
        .busy    (conv_busy),
        .ready   (conv_ready),
        .bcd_out (conv_bcd)
    );

endmodule

// File: tb/tb_calc_alu_seq.sv
// Randomised and directed bench for calc_alu_seq against an arithmetic reference model.
module tb_calc_alu_seq;

    logic        CLK_1K = 1'b0;
    logic        RSTN;
    logic        start;
    logic [3:0]  opcode;
    logic [23:0] num_a, num_b;
    logic        busy, done, neg, ovf, err;
    logic [23:0] num_result;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    calc_alu_seq dut (
        .CLK_1K     (CLK_1K),
        .RSTN       (RSTN),
        .start      (start),
        .opcode     (opcode),
        .num_a      (num_a),
        .num_b      (num_b),
        .busy       (busy),
        .done       (done),
        .num_result (num_result),
        .neg        (neg),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 CLK_1K = ~CLK_1K;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                         output logic [23:0] res, output logic e_neg, output logic e_ovf,
                         output logic e_err, output int lat);
        longint va, vb, r;
        bit bad;
        va = 0; vb = 0; r = 0; bad = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1'b1;
            va = va * 10 + longint'(a[i*4 +: 4]);
            vb = vb * 10 + longint'(b[i*4 +: 4]);
        end
        case (op)
            4'ha: r = va + vb;
            4'hb: r = va - vb;
            4'hc: r = va * vb;
            4'hd: if (DIV_EN && vb != 0) r = va / vb; else bad = 1'b1;
            default: bad = 1'b1;
        endcase
        lat   = (op == 4'hc || op == 4'hd) ? 47 : 28;
        e_neg = (op == 4'hb) && (r < 0);
        if (r < 0) r = -r;
        e_ovf = (r > 999999);
        e_err = bad;
        res   = 24'h999999;
        if (bad) begin
            res = '0; e_neg = 1'b0; e_ovf = 1'b0;
        end else if (!e_ovf) begin
            for (int i = 0; i < 6; i++) begin
                res[i*4 +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op, input bit dup);
        logic [23:0] e_res, g_res;
        logic        e_neg, e_ovf, e_err, g_neg, g_ovf, g_err;
        int          e_lat, lat, busy_low, extra;
        model(a, b, op, e_res, e_neg, e_ovf, e_err, e_lat);
        num_a = a; num_b = b; opcode = op; start = 1'b1;
        @(posedge CLK_1K); #1;
        start = 1'b0;
        num_a = $urandom; num_b = $urandom; opcode = 4'($urandom);
        chk("busy_rise", {31'd0, busy}, 1);
        lat = 0; busy_low = 0;
        g_res = 'x; g_neg = 1'bx; g_ovf = 1'bx; g_err = 1'bx;
        for (int n = 1; n <= 80 && lat == 0; n++) begin
            start = dup && (n == 10);
            @(posedge CLK_1K); #1;
            if (done) begin
                lat = n; g_res = num_result; g_neg = neg; g_ovf = ovf; g_err = err;
            end else if (!busy) begin
                busy_low++;
            end
        end
        start = dup;
        chk("latency", lat, e_lat);
        chk("result", {8'd0, g_res}, {8'd0, e_res});
        chk("neg", {31'd0, g_neg}, {31'd0, e_neg});
        chk("ovf", {31'd0, g_ovf}, {31'd0, e_ovf});
        chk("err", {31'd0, g_err}, {31'd0, e_err});
        chk("busy_gap", busy_low, 0);
        @(posedge CLK_1K); #1;
        start = 1'b0;
        chk("idle_after", {30'd0, busy, done}, 0);
        chk("hold", {8'd0, num_result}, {8'd0, e_res});
        if (dup) begin
            extra = 0;
            repeat (60) begin
                @(posedge CLK_1K); #1;
                if (done || busy) extra++;
            end
            chk("dup_start_ignored", extra, 0);
        end
    endtask

    function automatic logic [23:0] rnd_bcd(input int ndig);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < ndig; i++) begin
            r[i*4 +: 4] = ($urandom_range(15, 0) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9, 0));
        end
        return r;
    endfunction

    initial begin
        int k, nd;
        int stray;
        logic [3:0] op;
        RSTN = 1'b0; start = 1'b0; opcode = '0; num_a = '0; num_b = '0;
        #2;
        chk("reset_state", {3'd0, busy, done, neg, ovf, err, num_result}, 0);
        repeat (3) @(posedge CLK_1K);
        #1 RSTN = 1'b1;

        run_op(24'h000123, 24'h000456, 4'ha, 1'b0);
        run_op(24'h000005, 24'h000012, 4'hb, 1'b0);
        run_op(24'h000012, 24'h000012, 4'hb, 1'b0);
        run_op(24'h000999, 24'h001001, 4'hc, 1'b0);
        run_op(24'h001000, 24'h001000, 4'hc, 1'b0);
        run_op(24'h000007, 24'h000002, 4'hd, 1'b0);
        run_op(24'h000100, 24'h000000, 4'hd, 1'b0);
        run_op(24'h00001A, 24'h000003, 4'ha, 1'b0);
        run_op(24'h000004, 24'h000003, 4'he, 1'b0);
        run_op(24'h999999, 24'h000001, 4'ha, 1'b1);
        run_op(24'h999999, 24'h999999, 4'hd, 1'b0);

        for (int t = 0; t < 30; t++) begin
            k  = $urandom_range(9, 0);
            op = (k < 8) ? 4'(4'ha + 4'(k % 4)) : 4'($urandom);
            nd = $urandom_range(6, 1);
            run_op(rnd_bcd(nd), rnd_bcd($urandom_range(6, 1)), op, 1'b0);
        end

        // abort a multiply with reset while outputs hold a saturated result
        run_op(24'h001000, 24'h001000, 4'hc, 1'b0);
        num_a = 24'h000321; num_b = 24'h000123; opcode = 4'hc; start = 1'b1;
        @(posedge CLK_1K); #1;
        start = 1'b0;
        repeat (20) @(posedge CLK_1K);
        #1 RSTN = 1'b0;
        #1;
        chk("abort_result", {8'd0, num_result}, 0);
        chk("abort_flags", {27'd0, busy, done, neg, ovf, err}, 0);
        @(posedge CLK_1K); #1;
        RSTN = 1'b1;
        stray = 0;
        repeat (60) begin
            @(posedge CLK_1K); #1;
            if (done || busy) stray++;
        end
        chk("abort_no_done", stray, 0);
        run_op(24'h000250, 24'h000750, 4'ha, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
